mem_wb_stage: RTL
=================

MEM_WB_STAGE -- requirements
Module: mem_wb_stage

Interface
REQ-001 SHALL have clk  in  1  single clock; all state updates on rising edge.
REQ-002 SHALL have rst  in  1  reset, synchronous, active-high.
REQ-003 SHALL have valid_in  in  1  EX/MEM register holds a live instruction.
REQ-004 SHALL have reg_write_en_in, MemtoReg_in, MemRead_in, MemWrite_in  in  1 each  control from EX/MEM register.
REQ-005 SHALL have funct3_in  in  3  access size: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-006 SHALL have alu_result_in  in  32  effective address or ALU result.
REQ-007 SHALL have rs2_data_in  in  32  store data.
REQ-008 SHALL have rd_addr_in  in  5  destination register.
REQ-009 SHALL have dmem_req  out  1  memory request.
REQ-010 SHALL have dmem_we  out  1  write when 1.
REQ-011 SHALL have dmem_addr  out  32  word address, bits [1:0] forced 00.
REQ-012 SHALL have dmem_wdata  out  32  lane-replicated store data.
REQ-013 SHALL have dmem_be  out  4  byte enables.
REQ-014 SHALL have dmem_rdata  in  32  read word, valid when dmem_ack=1.
REQ-015 SHALL have dmem_ack  in  1  one-cycle completion pulse.
REQ-016 SHALL have stall_out  out  1  upstream pipeline holds while 1.
REQ-017 SHALL have wb_reg_write_en  out  1;  wb_rd_addr  out  5;  wb_rd_data  out  32  registered write-back port to register file.
REQ-018 SHALL have mem_exc  out  1  one-cycle pulse on misaligned or illegal-size access.

Function
REQ-019 SHALL implement FSM with states IDLE, ACCESS, DONE.
REQ-020 Memory op = valid_in & (MemRead_in | MemWrite_in); legal = funct3 in {000,001,010,100,101} and aligned (H/HU: addr[0]=0; W: addr[1:0]=00).
REQ-021 IDLE, legal memory op present: stall_out=1 combinationally; latch addr/we/be/wdata/funct3/rd/controls; next state ACCESS.
REQ-022 ACCESS: dmem_req=1 from latched values, held stable; stall_out=1; on dmem_ack=1 capture dmem_rdata, next state DONE; else remain (no timeout).
REQ-023 DONE: stall_out=0; WB register loads the completed instruction at this edge; next state IDLE.
REQ-024 dmem_req SHALL be 0 in IDLE and DONE; dmem_ack outside ACCESS SHALL be ignored.
REQ-025 Non-memory valid instruction in IDLE: stall_out=0; WB register loads it at the edge (1-cycle latency to wb_* outputs).
REQ-026 Memory op latency: arrival cycle N, ack at cycle N+k (k>=1), wb_* valid at cycle N+k+2.
REQ-027 Illegal/misaligned memory op: no dmem_req; stall_out=0; treated as bubble (wb_reg_write_en=0); mem_exc=1 the following cycle.
REQ-028 Store lanes: SB be=0001<<addr[1:0], wdata={4{rs2[7:0]}}; SH be=0011 (addr[1]=0) or 1100, wdata={2{rs2[15:0]}}; SW be=1111, wdata=rs2.
REQ-029 Load: dmem_we=0, be per REQ-028 size rules; extract lane by addr[1:0]; B/H sign-extend, BU/HU zero-extend, W unchanged.
REQ-030 wb_rd_data SHALL be load data if MemtoReg else alu_result; stores SHALL force wb_reg_write_en=0.
REQ-031 wb_reg_write_en SHALL be 0 when rd=0, when valid_in=0, or for bubbles.
REQ-032 While stall_out=1 the WB register SHALL load a bubble (wb_reg_write_en=0), not the stalled instruction.

Reset
REQ-033 rst=1 at an edge SHALL force state IDLE, wb_reg_write_en=0, wb_rd_addr=0, wb_rd_data=0, mem_exc=0, dmem_req=0 next cycle, all latches 0.
REQ-034 rst during ACCESS SHALL abandon the access; a later dmem_ack SHALL be ignored; no write-back of that instruction.

Verification
REQ-035 ALU op rd=5, alu_result=0x0000_002A, reg_write_en=1 -> next cycle wb_reg_write_en=1, wb_rd_addr=5, wb_rd_data=0x2A; stall_out never 1.
REQ-036 LB addr=0x103, rdata=0x80FF_1234, ack after 3 ACCESS cycles -> stall_out high 4 cycles, dmem_addr=0x100, be=1000, wb_rd_data=0xFFFF_FF80.
REQ-037 SH addr=0x206, rs2=0x1234_ABCD, ack immediate -> dmem_we=1, be=1100, wdata=0xABCD_ABCD, wb_reg_write_en=0.
REQ-038 LW addr=0x102 -> no dmem_req, mem_exc pulse 1 cycle, stall_out=0, no write-back.
REQ-039 LW to rd=0 -> access completes, wb_reg_write_en=0.
REQ-040 rst asserted 2 cycles into ACCESS, ack arrives next cycle -> IDLE, dmem_req=0, outputs zero, no write-back.

Source files
------------

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: combined MEM and WB pipeline stage for a 32-bit RV core.
//   Memory ops (loads/stores) run through a 3-state FSM: IDLE, ACCESS, DONE.
//   Non-memory instructions pass straight to the WB register with 1-cycle latency.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   valid_in .. rd_addr_in  EX/MEM register contents
//   dmem_*                data memory request/response handshake
//   stall_out             holds the upstream pipeline while a memory op is in flight
//   wb_*                  registered register-file write port
//   mem_exc               one-cycle pulse after a misaligned or illegal-size access

// Per-byte-lane store steering: byte enable and the byte placed on this lane.
//   size    : funct3[1:0] (00 byte, 01 half, 10 word)
//   addr_lo : address bits [1:0]
//   wdata   : unshifted store data
module mem_wb_lane #(
  parameter int LANE      = 0,
  parameter int NUM_LANES = 4,
  parameter int VEC_W     = 8
) (
  input  logic [1:0]                 size,
  input  logic [1:0]                 addr_lo,
  input  logic [NUM_LANES*VEC_W-1:0] wdata,
  output logic                       be,
  output logic [VEC_W-1:0]           wbyte
);
  localparam logic [1:0] LANE_IDX = 2'(LANE);

  always_comb begin
    be    = 1'b0;
    wbyte = '0;
    case (size)
      2'b00: begin
        be    = (addr_lo == LANE_IDX);
        wbyte = wdata[VEC_W-1:0];
      end
      2'b01: begin
        // halfword pair selected by addr[1]; low/high byte by lane parity
        be    = (addr_lo[1] == LANE_IDX[1]);
        wbyte = wdata[VEC_W*(LANE%2) +: VEC_W];
      end
      2'b10: begin
        be    = 1'b1;
        wbyte = wdata[VEC_W*LANE +: VEC_W];
      end
      default: begin
        be    = 1'b0;
        wbyte = '0;
      end
    endcase
  end
endmodule

module mem_wb_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_in,
  input  logic        reg_write_en_in,
  input  logic        MemtoReg_in,
  input  logic        MemRead_in,
  input  logic        MemWrite_in,
  input  logic [2:0]  funct3_in,
  input  logic [31:0] alu_result_in,
  input  logic [31:0] rs2_data_in,
  input  logic [4:0]  rd_addr_in,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        stall_out,
  output logic        wb_reg_write_en,
  output logic [4:0]  wb_rd_addr,
  output logic [31:0] wb_rd_data,
  output logic        mem_exc
);
  localparam int NUM_LANES = 4;
  localparam int VEC_W     = 8;
  localparam int XLEN      = NUM_LANES * VEC_W;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  // Memory op captured in IDLE and held stable for the whole access.
  typedef struct packed {
    logic                 reg_write_en;
    logic                 mem_to_reg;
    logic                 we;
    logic [2:0]           funct3;
    logic [4:0]           rd;
    logic [NUM_LANES-1:0] be;
    logic [XLEN-1:0]      addr;   // full ALU result; also the non-MemtoReg write-back value
    logic [XLEN-1:0]      wdata;
  } mem_req_t;

  typedef struct packed {
    logic            en;
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } wb_t;

  state_t   state_q, state_d;
  mem_req_t lat_q, new_req;
  wb_t      wb_q, wb_d;
  logic [XLEN-1:0] rdata_q;
  logic     lat_load, rdata_load;
  logic     exc_q, exc_d;
  logic     mem_op, legal;

  // ---------------- store lane steering ----------------
  logic [NUM_LANES-1:0][VEC_W-1:0] st_bytes;
  logic [NUM_LANES-1:0]            st_be;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    mem_wb_lane #(
      .LANE      (g),
      .NUM_LANES (NUM_LANES),
      .VEC_W     (VEC_W)
    ) u_lane (
      .size    (funct3_in[1:0]),
      .addr_lo (alu_result_in[1:0]),
      .wdata   (rs2_data_in),
      .be      (st_be[g]),
      .wbyte   (st_bytes[g])
    );
  end

  assign mem_op = valid_in & (MemRead_in | MemWrite_in);

  always_comb begin
    legal = 1'b0;
    case (funct3_in)
      3'b000, 3'b100: legal = 1'b1;
      3'b001, 3'b101: legal = ~alu_result_in[0];
      3'b010:         legal = (alu_result_in[1:0] == 2'b00);
      default:        legal = 1'b0;
    endcase
  end

  always_comb begin
    new_req              = '0;
    new_req.reg_write_en = reg_write_en_in;
    new_req.mem_to_reg   = MemtoReg_in;
    new_req.we           = MemWrite_in;
    new_req.funct3       = funct3_in;
    new_req.rd           = rd_addr_in;
    new_req.be           = st_be;
    new_req.addr         = alu_result_in;
    new_req.wdata        = st_bytes;
  end

  // ---------------- load extraction ----------------
  logic [NUM_LANES-1:0][VEC_W-1:0] rd_bytes;
  logic [7:0]      ld_byte;
  logic [15:0]     ld_half;
  logic [XLEN-1:0] ld_data;

  assign rd_bytes = rdata_q;
  assign ld_byte  = rd_bytes[lat_q.addr[1:0]];
  assign ld_half  = lat_q.addr[1] ? rdata_q[31:16] : rdata_q[15:0];

  always_comb begin
    ld_data = rdata_q;
    case (lat_q.funct3)
      3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  ld_data = {24'd0, ld_byte};
      3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b101:  ld_data = {16'd0, ld_half};
      default: ld_data = rdata_q;
    endcase
  end

  // ---------------- FSM next-state / outputs ----------------
  // The WB register defaults to a bubble; only a non-memory instruction in
  // IDLE or a completed access in DONE produces a live write-back.
  always_comb begin
    state_d    = state_q;
    stall_out  = 1'b0;
    lat_load   = 1'b0;
    rdata_load = 1'b0;
    exc_d      = 1'b0;
    wb_d       = '0;
    case (state_q)
      IDLE: begin
        if (mem_op) begin
          if (legal) begin
            stall_out = 1'b1;
            lat_load  = 1'b1;
            state_d   = ACCESS;
          end else begin
            exc_d = 1'b1;
          end
        end else if (valid_in) begin
          wb_d.en   = reg_write_en_in & (rd_addr_in != 5'd0);
          wb_d.rd   = rd_addr_in;
          wb_d.data = alu_result_in;
        end
      end
      ACCESS: begin
        stall_out = 1'b1;
        if (dmem_ack) begin
          rdata_load = 1'b1;
          state_d    = DONE;
        end
      end
      DONE: begin
        // EX/MEM still shows the finished op this cycle; its inputs are ignored.
        wb_d.en   = lat_q.reg_write_en & ~lat_q.we & (lat_q.rd != 5'd0);
        wb_d.rd   = lat_q.rd;
        wb_d.data = lat_q.mem_to_reg ? ld_data : lat_q.addr;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      lat_q   <= '0;
      rdata_q <= '0;
      wb_q    <= '0;
      exc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (lat_load)   lat_q   <= new_req;
      if (rdata_load) rdata_q <= dmem_rdata;
      wb_q    <= wb_d;
      exc_q   <= exc_d;
    end
  end

  assign dmem_req        = (state_q == ACCESS);
  assign dmem_we         = dmem_req & lat_q.we;
  assign dmem_addr       = {lat_q.addr[31:2], 2'b00};
  assign dmem_wdata      = lat_q.wdata;
  assign dmem_be         = lat_q.be;
  assign wb_reg_write_en = wb_q.en;
  assign wb_rd_addr      = wb_q.rd;
  assign wb_rd_data      = wb_q.data;
  assign mem_exc         = exc_q;
endmodule
